// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared encodings for the CPU load/store front end
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR   = 3'd3,
        WR_B = 3'd4,
        RESP = 3'd5
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store strobe/lane replication and load extract/extend
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_signed,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_lanes,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_ext
);

    logic [31:0] sh;

    // Bring the addressed lane down to bit 0 for extraction.
    assign sh = ld_data >> {off, 3'b000};

    // Size decode; the reserved encoding falls through to word behaviour.
    always_comb begin
        st_strb  = 4'b1111;
        st_lanes = st_data;
        ld_ext   = ld_data;
        case (size)
            SZ_BYTE: begin
                st_strb  = 4'b0001 << off;
                st_lanes = {4{st_data[7:0]}};
                ld_ext   = {{24{is_signed & sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                st_strb  = off[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
                ld_ext   = {{16{is_signed & sh[15]}}, sh[15:0]};
            end
            default: begin
                st_strb  = 4'b1111;
                st_lanes = st_data;
                ld_ext   = ld_data;
            end
        endcase
    end

endmodule

// File: rtl/cpu_mem_port.sv
// rtl/cpu_mem_port.sv - scalar load/store to AXI-lite master bridge; MISALIGN_TRAP_EN enables misalign trapping
module cpu_mem_port
    import cpu_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,

    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,

    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,

    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    state_t state;

    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        signed_q;
    logic        aw_done;
    logic        w_done;

    logic [31:0]       addr_m;
    logic [ADDR_W-1:0] eff;
    logic              trap;

    logic [1:0]  al_size;
    logic [1:0]  al_off;
    logic [3:0]  al_strb;
    logic [31:0] al_lanes;
    logic [31:0] al_ld;

    logic aw_fire;
    logic w_fire;
    logic aw_done_n;
    logic w_done_n;

    // Clear low address bits that the access size cannot use.
    always_comb begin
        addr_m = req_addr;
        case (req_size)
            SZ_BYTE: addr_m = req_addr;
            SZ_HALF: addr_m[0] = 1'b0;
            default: addr_m[1:0] = 2'b00;
        endcase
    end

    assign eff = ADDR_W'(addr_m) + ADDR_OFFSET;

`ifdef MISALIGN_TRAP_EN
    // Misaligned half/word accesses complete with an error and no bus traffic.
    always_comb begin
        trap = 1'b0;
        case (req_size)
            SZ_BYTE: trap = 1'b0;
            SZ_HALF: trap = req_addr[0];
            default: trap = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Stores are laned from the live request in IDLE; loads use the latched request.
    assign al_size = (state == IDLE) ? req_size    : size_q;
    assign al_off  = (state == IDLE) ? addr_m[1:0] : off_q;

    mem_lane_align u_align (
        .size      (al_size),
        .off       (al_off),
        .is_signed (signed_q),
        .st_data   (req_wdata),
        .st_strb   (al_strb),
        .st_lanes  (al_lanes),
        .ld_data   (m_axi_rdata),
        .ld_ext    (al_ld)
    );

    assign aw_fire   = m_axi_awvalid & m_axi_awready;
    assign w_fire    = m_axi_wvalid  & m_axi_wready;
    assign aw_done_n = aw_done | aw_fire;
    assign w_done_n  = w_done  | w_fire;

    // Transaction sequencer with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            size_q        <= SZ_BYTE;
            off_q         <= 2'b00;
            signed_q      <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q    <= req_size;
                        off_q     <= addr_m[1:0];
                        signed_q  <= req_signed;
                        req_ready <= 1'b0;
                        if (trap) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (req_we) begin
                            m_axi_awaddr  <= eff;
                            m_axi_wdata   <= al_lanes;
                            m_axi_wstrb   <= al_strb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= WR;
                        end else begin
                            m_axi_araddr  <= eff;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_D;
                    end
                end
                RD_D: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_err     <= (m_axi_rresp != AXI_RESP_OKAY);
                        resp_rdata   <= (m_axi_rresp != AXI_RESP_OKAY) ? 32'h0 : al_ld;
                        state        <= RESP;
                    end
                end
                WR: begin
                    if (aw_fire) m_axi_awvalid <= 1'b0;
                    if (w_fire)  m_axi_wvalid  <= 1'b0;
                    aw_done <= aw_done_n;
                    w_done  <= w_done_n;
                    if (aw_done_n && w_done_n) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_err     <= (m_axi_bresp != AXI_RESP_OKAY);
                        resp_rdata   <= '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_mem_port.md
Name: cpu_mem_port

Overview:
- CPU-side load/store front end that sits directly upstream of the 1 MB direct-mapped data cache.
- Accepts one scalar load/store at a time from the core (byte, half or word, signed or unsigned) and converts it into the 32-bit AXI-lite master transaction the cache's slave port consumes.
- Generates write strobes and lane-replicated write data for stores. Extracts and extends the addressed lanes for loads.
- Returns a single-cycle response to the core.

Parameters:
- ADDR_W, 32, width of the address issued on m_axi_araddr/m_axi_awaddr.
- ADDR_OFFSET, 0, constant added to the CPU address before issue; the sum is taken modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  block idle, request accepted when req_valid&&req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  AXI error or misalign trap
- m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read address channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel
- m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel

Behaviour:
- Reset values: req_ready=1; resp_valid, resp_err, all *valid, rready and bready = 0; resp_rdata, addresses, wdata and wstrb = 0. State = IDLE.
- Reset mid-transaction drops every valid/ready on the next edge. The transaction is abandoned; the system must reset the cache alongside this block.
- States: IDLE, RD_A, RD_D, WR, WR_B, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, size, signed and we; compute eff = req_addr+ADDR_OFFSET; req_ready falls.
  - Next cycle: loads go to RD_A with arvalid=1 and araddr=eff. Stores go to WR with awvalid=wvalid=1 in the same cycle.
- RD_A: hold arvalid/araddr stable until arready. On the handshake cycle drop arvalid and raise rready, then go to RD_D.
- RD_D: on rvalid&&rready drop rready, capture rdata/rresp, go to RESP.
- WR:
  - Track aw_done and w_done independently. Each valid drops on its own handshake.
  - The cache raises wready only after accepting AW; the block must not wait for wready before awready.
  - When both are done, raise bready and go to WR_B.
- WR_B: on bvalid drop bready, capture bresp, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err=(captured resp != 0).
  - Return to IDLE with req_ready=1 the following cycle.
  - No back-pressure from the core.
- Store lane generation (off = addr[1:0]):
  - byte: wstrb = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'b1111, wdata passthrough.
- Load extraction: sh = rdata >> (8*off). Byte uses sh[7:0] and half uses sh[15:0], each zero- or sign-extended per req_signed; word uses rdata unmodified.
- resp_rdata=0 when resp_err=1 or for stores.
- Minimum latency with an always-ready cache: accept at cycle 0, arvalid at 1, RESP pulse no earlier than 3. Actual latency is dominated by cache miss handling.
- Only one outstanding transaction; the AXI IDs are implicit.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - A half access with addr[0]=1, or a word/reserved access with addr[1:0]!=0, issues no AXI traffic.
  - IDLE goes straight to RESP with resp_err=1 and resp_rdata=0; this is a 2-cycle turnaround.
- When undefined: misaligned low bits are cleared (half: addr[0]=0; word: addr[1:0]=0) before issue and lane generation, and the access completes normally.

Decomposition:
- Package cpu_mem_pkg holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the state enum;
  - AXI_RESP_OKAY=2'b00.
- One sub-module, mem_lane_align: purely combinational store strobe/data replication plus load extract/extend, shared by both paths.

Test Plan:
- Load word at 0x0000_1000, cache returns rdata=0xDEADBEEF, rresp=0 -> resp_rdata=0xDEADBEEF, resp_err=0, exactly one resp_valid pulse.
- Signed byte load at 0x...1003 with rdata=0x80FF_0000 -> resp_rdata=0xFFFF_FF80; the same access unsigned -> 0x0000_0080.
- Store half 0xABCD at 0x...2002 -> wstrb=4'b1100, wdata=0xABCDABCD. The bench delays wready 5 cycles after awready; awvalid must drop on its handshake and wvalid must be held until wready.
- Error responses: bresp=2'b10 on a store -> resp_err=1; rresp=2'b11 on a load -> resp_err=1, resp_rdata=0.
- Word load at 0x...0006: MISALIGN_TRAP_EN defined -> no arvalid ever, resp_err=1; undefined -> araddr=0x...0004.
- Assert rst while in RD_D with rready=1 -> next edge rready=0, req_ready=1; a subsequent request after the bench resets the cache completes normally.
